// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared pipeline types: forwarding-select encoding, hazard FSM states and the zero-register id.
package pipeline_pkg;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } hz_state_t;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/forwarding_hazard_unit_fwd_compare.sv
// Per-operand source match against ID/EX and EX/MEM with ID/EX priority.
module fwd_compare
    import pipeline_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] idex_rd,
    input  logic          idex_wb,
    input  logic [AW-1:0] exmem_rd,
    input  logic          exmem_wb,
    input  logic          use_idex,
    output logic          idex_hit,
    output fwd_sel_t      sel
);

    logic exmem_hit;

    assign idex_hit  = idex_wb && (idex_rd != AW'(REG_ZERO)) && (idex_rd == src);
    assign exmem_hit = exmem_wb && (exmem_rd != AW'(REG_ZERO)) && (exmem_rd == src);

    // use_idex is low on stall release, when ID/EX holds a bubble
    always_comb begin
        sel = FWD_REG;
        if (use_idex && idex_hit) begin
            sel = FWD_EXMEM;
        end else if (exmem_hit) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Registered EX operand forwarding selects plus load-use stall FSM with flush cancel.
// Optional statistics counters are built when FWD_STATS_EN is defined.
module forwarding_hazard_unit
    import pipeline_pkg::*;
#(
    parameter int REG_AW            = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int STAT_W            = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [REG_AW-1:0] IDRs,
    input  logic [REG_AW-1:0] IDRt,
    input  logic [REG_AW-1:0] IDEXRd,
    input  logic              IDEX_WB,
    input  logic              IDEX_MemRead,
    input  logic [REG_AW-1:0] EXMEMRd,
    input  logic              EXMEM_WB,
    input  logic              Flush,
    output logic [1:0]        Amux_control,
    output logic [1:0]        Bmux_control,
    output logic              Stall,
    output logic              Bubble
`ifdef FWD_STATS_EN
    ,
    output logic [STAT_W-1:0] Stall_count,
    output logic [STAT_W-1:0] Fwd_count
`endif
);

    hz_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] pend_q, pend_d;
    fwd_sel_t   amux_q, amux_d, bmux_q, bmux_d;
    fwd_sel_t   a_sel, b_sel;
    logic       a_idex_hit, b_idex_hit;
    logic       use_idex, hazard, stall_c;

    assign use_idex = (state_q == IDLE);

    fwd_compare #(.AW(REG_AW)) u_cmp_a (
        .src      (IDRs),
        .idex_rd  (IDEXRd),
        .idex_wb  (IDEX_WB),
        .exmem_rd (EXMEMRd),
        .exmem_wb (EXMEM_WB),
        .use_idex (use_idex),
        .idex_hit (a_idex_hit),
        .sel      (a_sel)
    );

    fwd_compare #(.AW(REG_AW)) u_cmp_b (
        .src      (IDRt),
        .idex_rd  (IDEXRd),
        .idex_wb  (IDEX_WB),
        .exmem_rd (EXMEMRd),
        .exmem_wb (EXMEM_WB),
        .use_idex (use_idex),
        .idex_hit (b_idex_hit),
        .sel      (b_sel)
    );

    assign hazard = IDEX_MemRead && (a_idex_hit || b_idex_hit);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        amux_d  = a_sel;
        bmux_d  = b_sel;
        stall_c = 1'b0;
        if (Flush) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            pend_d  = 2'b00;
            amux_d  = FWD_REG;
            bmux_d  = FWD_REG;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hazard) begin
                        stall_c = 1'b1;
                        state_d = STALL;
                        cnt_d   = 4'(LOAD_STALL_CYCLES - 1);
                        pend_d  = {b_idex_hit, a_idex_hit};
                        amux_d  = FWD_REG;
                        bmux_d  = FWD_REG;
                    end
                end
                STALL: begin
                    if (cnt_q != 4'd0) begin
                        stall_c = 1'b1;
                        cnt_d   = cnt_q - 4'd1;
                        amux_d  = FWD_REG;
                        bmux_d  = FWD_REG;
                    end else begin
                        // load data now sits in MEM/WB
                        state_d = IDLE;
                        pend_d  = 2'b00;
                        if (pend_q[0]) amux_d = FWD_MEMWB;
                        if (pend_q[1]) bmux_d = FWD_MEMWB;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            pend_q  <= 2'b00;
            amux_q  <= FWD_REG;
            bmux_q  <= FWD_REG;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            amux_q  <= amux_d;
            bmux_q  <= bmux_d;
        end
    end

    // hazard inputs may be live while held in reset
    assign Stall        = stall_c && Rst_n;
    assign Bubble       = stall_c && Rst_n;
    assign Amux_control = amux_q;
    assign Bmux_control = bmux_q;

`ifdef FWD_STATS_EN
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STAT_W'(1);
        if (((amux_d != FWD_REG) || (bmux_d != FWD_REG)) && (fwd_cnt_q != '1))
            fwd_cnt_d = fwd_cnt_q + STAT_W'(1);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign Stall_count = stall_cnt_q;
    assign Fwd_count   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Scoreboard bench: two units (1 and 3 load bubbles) share stimulus; a negedge monitor checks each cycle.
module tb_forwarding_hazard_unit;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic [4:0] IDRs = '0, IDRt = '0, IDEXRd = '0, EXMEMRd = '0;
    logic       IDEX_WB = 1'b0, IDEX_MemRead = 1'b0, EXMEM_WB = 1'b0, Flush = 1'b0;

    logic [1:0] a1, b1, a3, b3;
    logic       s1, bb1, s3, bb3;
`ifdef FWD_STATS_EN
    logic [15:0] sc1, fc1, sc3, fc3;
`endif

    always #5 Clk = ~Clk;

    forwarding_hazard_unit #(.REG_AW(5), .LOAD_STALL_CYCLES(1), .STAT_W(16)) u_dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .IDRs(IDRs), .IDRt(IDRt), .IDEXRd(IDEXRd),
        .IDEX_WB(IDEX_WB), .IDEX_MemRead(IDEX_MemRead), .EXMEMRd(EXMEMRd),
        .EXMEM_WB(EXMEM_WB), .Flush(Flush), .Amux_control(a1), .Bmux_control(b1),
        .Stall(s1), .Bubble(bb1)
`ifdef FWD_STATS_EN
        , .Stall_count(sc1), .Fwd_count(fc1)
`endif
    );

    forwarding_hazard_unit #(.REG_AW(5), .LOAD_STALL_CYCLES(3), .STAT_W(16)) u_dut3 (
        .Clk(Clk), .Rst_n(Rst_n), .IDRs(IDRs), .IDRt(IDRt), .IDEXRd(IDEXRd),
        .IDEX_WB(IDEX_WB), .IDEX_MemRead(IDEX_MemRead), .EXMEMRd(EXMEMRd),
        .EXMEM_WB(EXMEM_WB), .Flush(Flush), .Amux_control(a3), .Bmux_control(b3),
        .Stall(s3), .Bubble(bb3)
`ifdef FWD_STATS_EN
        , .Stall_count(sc3), .Fwd_count(fc3)
`endif
    );

    typedef struct {
        int         idx;
        logic       s1;
        logic [1:0] a1, b1;
        logic       s3;
        logic [1:0] a3, b3;
        bit         chk_sc;
        int         sc1, sc3;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   failed = 0;
    int   vec = 0;
    bit   chk_sc_next = 0;
    int   sc1_next = 0, sc3_next = 0;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic cyc(input logic rst, input int rs, input int rt, input int xr,
                       input logic xw, input logic xm, input int mr, input logic mw,
                       input logic fl, input logic e_s1, input int e_a1, input int e_b1,
                       input logic e_s3, input int e_a3, input int e_b3);
        exp_t e;
        @(posedge Clk);
        #1;
        Rst_n = rst;
        IDRs = 5'(rs); IDRt = 5'(rt); IDEXRd = 5'(xr); IDEX_WB = xw; IDEX_MemRead = xm;
        EXMEMRd = 5'(mr); EXMEM_WB = mw; Flush = fl;
        e.idx = vec; e.s1 = e_s1; e.a1 = 2'(e_a1); e.b1 = 2'(e_b1);
        e.s3 = e_s3; e.a3 = 2'(e_a3); e.b3 = 2'(e_b3);
        e.chk_sc = chk_sc_next; e.sc1 = sc1_next; e.sc3 = sc3_next;
        chk_sc_next = 0;
        q.push_back(e);
        vec++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("stall1",  e.idx, int'(s1),  int'(e.s1));
                chk("bubble1", e.idx, int'(bb1), int'(e.s1));
                chk("amux1",   e.idx, int'(a1),  int'(e.a1));
                chk("bmux1",   e.idx, int'(b1),  int'(e.b1));
                chk("stall3",  e.idx, int'(s3),  int'(e.s3));
                chk("bubble3", e.idx, int'(bb3), int'(e.s3));
                chk("amux3",   e.idx, int'(a3),  int'(e.a3));
                chk("bmux3",   e.idx, int'(b3),  int'(e.b3));
`ifdef FWD_STATS_EN
                if (e.chk_sc) begin
                    chk("stall_count1", e.idx, int'(sc1), e.sc1);
                    chk("stall_count3", e.idx, int'(sc3), e.sc3);
                end
`endif
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: run did not complete");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1);
    end

    initial begin : driver
        //   rst rs rt xr xw xm mr mw fl | s1 a1 b1 s3 a3 b3
        // held in reset with a live load-use pair: nothing may assert
        cyc(0, 5, 5, 5, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        cyc(0, 5, 5, 5, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        // priority, EX/MEM match, zero register, WB gating, Rs==Rt
        cyc(1, 3, 4, 3, 1, 0, 3, 1, 0,   0, 0, 0, 0, 0, 0);
        cyc(1, 1, 4, 0, 1, 0, 4, 1, 0,   0, 2, 0, 0, 2, 0);
        cyc(1, 0, 0, 0, 1, 0, 0, 1, 0,   0, 0, 1, 0, 0, 1);
        cyc(1, 7, 7, 7, 0, 0, 7, 1, 0,   0, 0, 0, 0, 0, 0);
        cyc(1, 2, 6, 2, 1, 0, 6, 0, 0,   0, 1, 1, 0, 1, 1);
        // load-use on Rt
        cyc(1, 1, 5, 5, 1, 1, 1, 1, 0,   1, 2, 0, 1, 2, 0);
        cyc(1, 1, 5, 0, 0, 0, 5, 1, 0,   0, 0, 0, 1, 0, 0);
        cyc(1, 1, 5, 0, 0, 0, 5, 1, 0,   0, 0, 1, 1, 0, 0);
        chk_sc_next = 1; sc1_next = 1; sc3_next = 3;
        // release of the 3-bubble unit must ignore the ID/EX match on Rs
        cyc(1, 1, 5, 1, 1, 0, 5, 1, 0,   0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 2, 1, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        // flush on the second stall cycle (release cycle for the 1-bubble unit)
        cyc(1, 8, 9, 8, 1, 1, 0, 0, 0,   1, 0, 0, 1, 0, 0);
        cyc(1, 8, 9, 0, 0, 0, 8, 1, 1,   0, 0, 0, 0, 0, 0);
        cyc(1, 3, 0, 3, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 2, 0, 0, 2, 0);
        // flush together with a hazard in IDLE
        cyc(1, 4, 4, 4, 1, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        // Rs==Rt load-use, then back-to-back hazard at the 1-bubble release
        cyc(1, 6, 6, 6, 1, 1, 0, 0, 0,   1, 0, 0, 1, 0, 0);
        cyc(1, 6, 6, 0, 0, 0, 6, 1, 0,   0, 0, 0, 1, 0, 0);
        cyc(1, 6, 6, 6, 1, 1, 0, 0, 0,   1, 1, 1, 1, 0, 0);
        cyc(1, 6, 6, 0, 0, 0, 6, 1, 0,   0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 1, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        // reset in the middle of a stall, then normal forwarding
        cyc(1, 2, 0, 2, 1, 1, 0, 0, 0,   1, 0, 0, 1, 0, 0);
        cyc(1, 2, 0, 0, 0, 0, 2, 1, 0,   0, 0, 0, 1, 0, 0);
        cyc(0, 2, 0, 2, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        cyc(1, 3, 0, 3, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 2, 0, 0, 2, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);

        @(posedge Clk);
        @(negedge Clk);
        #1;
        chk("scoreboard_drained", vec, q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
